logic_reduce_acc: RTL and testbench



---
 rtl/hack_logic_pkg.sv | 16 +
 rtl/bitwise_op_unit.sv | 26 ++
 rtl/logic_reduce_acc.sv | 118 +++++++++++
 tb/tb_logic_reduce_acc.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/hack_logic_pkg.sv
// Shared encodings for the bitwise reduction datapath: operation select
// codes and the accumulator FSM states.
package hack_logic_pkg;

    localparam logic [1:0] OP_OR   = 2'b00;
    localparam logic [1:0] OP_AND  = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        HOLD  = 2'b10
    } state_e;

endpackage

// File: rtl/bitwise_op_unit.sv
// Combinational WIDTH-bit two-operand bitwise fold. NAND folds as AND;
// the final inversion is applied once at the output of the reducer.
module bitwise_op_unit
    import hack_logic_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Select the per-bit operation.
    always_comb begin
        y = a | b;
        case (op)
            OP_OR:   y = a | b;
            OP_AND:  y = a & b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = a & b;
            default: y = a | b;
        endcase
    end

endmodule

// File: rtl/logic_reduce_acc.sv
// Streaming N-way bitwise reducer: folds a burst of WIDTH-bit words with
// OR/AND/XOR/NAND and presents one result with word count and flags.
module logic_reduce_acc
    import hack_logic_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned MAX_WORDS = 8,
    parameter int unsigned CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_zero,
    output logic             out_forced
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);
    localparam bit               SINGLE  = (MAX_WORDS == 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       op_q, op_d;
    logic             forced_q, forced_d;
    logic [WIDTH-1:0] fold_res;
    logic [WIDTH-1:0] result;
    logic             hold;

    bitwise_op_unit #(
        .WIDTH (WIDTH)
    ) u_fold (
        .op (op_q),
        .a  (acc_q),
        .b  (in_data),
        .y  (fold_res)
    );

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            count_q  <= '0;
            op_q     <= OP_OR;
            forced_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            op_q     <= op_d;
            forced_q <= forced_d;
        end
    end

    // Next-state and datapath update; unused encodings behave as IDLE.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        count_d  = count_q;
        op_d     = op_q;
        forced_d = forced_q;
        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    acc_d   = fold_res;
                    count_d = count_q + ONE_CNT;
                    if (in_last) begin
                        state_d  = HOLD;
                        forced_d = 1'b0;
                    end else if (count_q + ONE_CNT == MAX_CNT) begin
                        state_d  = HOLD;
                        forced_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                if (in_valid) begin
                    acc_d   = in_data;
                    op_d    = op;
                    count_d = ONE_CNT;
                    if (in_last || SINGLE) begin
                        state_d  = HOLD;
                        forced_d = ~in_last;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
        endcase
    end

    // Outputs decoded from state; result fields read zero outside HOLD.
    always_comb begin
        hold       = (state_q == HOLD);
        result     = (op_q == OP_NAND) ? ~acc_q : acc_q;
        in_ready   = ~hold;
        out_valid  = hold;
        out_data   = hold ? result : '0;
        out_count  = hold ? count_q : '0;
        out_zero   = hold && (result == '0);
        out_forced = hold && forced_q;
    end

endmodule

// File: tb/tb_logic_reduce_acc.sv
// Directed self-checking bench for logic_reduce_acc (WIDTH=16, MAX_WORDS=8).
module tb_logic_reduce_acc;

    localparam int unsigned WIDTH     = 16;
    localparam int unsigned MAX_WORDS = 8;
    localparam int unsigned CNT_W     = $clog2(MAX_WORDS + 1);

    logic             clk;
    logic             rst_n;
    logic [1:0]       op;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_zero;
    logic             out_forced;

    int n_cmp = 0;
    int n_err = 0;

    logic_reduce_acc #(
        .WIDTH     (WIDTH),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_count  (out_count),
        .out_zero   (out_zero),
        .out_forced (out_forced)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one beat for one edge; outputs are sampled 1ns after that edge.
    task automatic send(input logic [15:0] d, input logic last, input logic [1:0] o);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        op       = o;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [15:0] d, input int cnt,
                                 input logic zero, input logic forced);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_data"}, 32'(out_data), 32'(d));
        check_eq({tag, "_count"}, 32'(out_count), 32'(cnt));
        check_eq({tag, "_zero"}, 32'(out_zero), 32'(zero));
        check_eq({tag, "_forced"}, 32'(out_forced), 32'(forced));
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        op        = 2'b00;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_data", 32'(out_data), 32'd0);
        check_eq("rst_count", 32'(out_count), 32'd0);
        check_eq("rst_zero", 32'(out_zero), 32'd0);
        check_eq("rst_forced", 32'(out_forced), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);

        // 1: OR of three words, latency one cycle after last beat
        send(16'h0001, 1'b0, 2'b00);
        send(16'h0100, 1'b0, 2'b00);
        check_eq("t1_pre_valid", 32'(out_valid), 32'd0);
        send(16'h8000, 1'b1, 2'b00);
        expect_result("t1", 16'h8101, 3, 1'b0, 1'b0);
        consume("t1");

        // 2: AND then NAND of the same pair
        send(16'hFFFF, 1'b0, 2'b01);
        send(16'h0F0F, 1'b1, 2'b01);
        expect_result("t2_and", 16'h0F0F, 2, 1'b0, 1'b0);
        consume("t2_and");
        send(16'hFFFF, 1'b0, 2'b11);
        send(16'h0F0F, 1'b1, 2'b11);
        expect_result("t2_nand", 16'hF0F0, 2, 1'b0, 1'b0);
        consume("t2_nand");

        // 3: XOR of eight words without last -> forced end, then new burst
        for (int i = 0; i < 8; i++) begin
            send(16'h00FF, 1'b0, 2'b10);
            if (i == 6) check_eq("t3_pre_valid", 32'(out_valid), 32'd0);
        end
        expect_result("t3", 16'h0000, 8, 1'b1, 1'b1);
        consume("t3");
        send(16'hABCD, 1'b1, 2'b00);
        expect_result("t3_next", 16'hABCD, 1, 1'b0, 1'b0);
        consume("t3_next");

        // 3b: last coinciding with MAX_WORDS is a normal end
        for (int i = 0; i < 8; i++) send(16'(1 << i), (i == 7), 2'b00);
        expect_result("t3b", 16'h00FF, 8, 1'b0, 1'b0);
        consume("t3b");

        // 4: backpressure, with an offered word that must not be taken
        send(16'h1111, 1'b0, 2'b00);
        send(16'h2222, 1'b1, 2'b00);
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            expect_result($sformatf("t4_c%0d", c), 16'h3333, 2, 1'b0, 1'b0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        consume("t4");

        // 5: reset mid-burst discards partial state
        send(16'h00F0, 1'b0, 2'b00);
        send(16'h0F00, 1'b0, 2'b00);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_eq("t5_valid", 32'(out_valid), 32'd0);
        check_eq("t5_data", 32'(out_data), 32'd0);
        check_eq("t5_count", 32'(out_count), 32'd0);
        check_eq("t5_zero", 32'(out_zero), 32'd0);
        check_eq("t5_forced", 32'(out_forced), 32'd0);
        check_eq("t5_in_ready", 32'(in_ready), 32'd1);
        send(16'h1234, 1'b1, 2'b00);
        expect_result("t5_post", 16'h1234, 1, 1'b0, 1'b0);
        consume("t5");

        // 6: op change mid-burst is ignored
        send(16'h0003, 1'b0, 2'b00);
        send(16'h0005, 1'b1, 2'b10);
        expect_result("t6", 16'h0007, 2, 1'b0, 1'b0);
        consume("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
